// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16-entry receive FIFO that sits between a UART receiver and the CPU.
//   Clock         system clock, rising edge
//   Reset         asynchronous active-low reset
//   RxReady/RxData/RxParityErr/RxFrameErr   receiver strobes and byte
//   ReadEn        pop the head entry; ReadData shows the head (first-word fall-through)
//   Flush         discard all entries; the error flags are kept
//   ClearErr      clear the sticky error flags
//   IntLevel      RxIntReq fires while Count > IntLevel
//   TimeoutLimit  idle clocks with data waiting before TimeoutIntReq
//   Count/Empty/Full, OverrunErr/ParityErrFlag/FrameErrFlag, RxIntReq, TimeoutIntReq
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout
// counter. Without it, TimeoutIntReq is tied low.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RxReady,
    input  logic [7:0]  RxData,
    input  logic        RxParityErr,
    input  logic        RxFrameErr,
    input  logic        ReadEn,
    input  logic        Flush,
    input  logic        ClearErr,
    input  logic [3:0]  IntLevel,
    input  logic [15:0] TimeoutLimit,
    output logic [7:0]  ReadData,
    output logic [4:0]  Count,
    output logic        Empty,
    output logic        Full,
    output logic        OverrunErr,
    output logic        ParityErrFlag,
    output logic        FrameErrFlag,
    output logic        RxIntReq,
    output logic        TimeoutIntReq
);

    logic [7:0] mem [DEPTH];
    logic [3:0] wrPtr;
    logic [3:0] rdPtr;
    logic       pushEn;
    logic       popEn;
    logic       overrunSet;

    assign Empty = (Count == 5'd0);
    assign Full  = (Count == 5'd16);

    // Flush overrides both operations. A push into a full FIFO is still
    // accepted when a pop frees the head slot in the same cycle.
    assign popEn      = ReadEn & ~Empty & ~Flush;
    assign pushEn     = RxReady & ~Flush & (~Full | popEn);
    assign overrunSet = RxReady & Full & ~ReadEn & ~Flush;

    assign ReadData = mem[rdPtr];

    // Storage is intentionally not reset.
    always_ff @(posedge Clock) begin
        if (pushEn)
            mem[wrPtr] <= RxData;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= 4'd0;
            rdPtr <= 4'd0;
            Count <= 5'd0;
        end else if (Flush) begin
            wrPtr <= 4'd0;
            rdPtr <= 4'd0;
            Count <= 5'd0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + 4'd1;
            if (popEn)  rdPtr <= rdPtr + 4'd1;
            case ({pushEn, popEn})
                2'b10:   Count <= Count + 5'd1;
                2'b01:   Count <= Count - 5'd1;
                default: Count <= Count;
            endcase
        end
    end

    // Sticky flags: a same-cycle set beats ClearErr.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            OverrunErr    <= 1'b0;
            ParityErrFlag <= 1'b0;
            FrameErrFlag  <= 1'b0;
        end else begin
            if (overrunSet)       OverrunErr <= 1'b1;
            else if (ClearErr)    OverrunErr <= 1'b0;
            if (RxParityErr)      ParityErrFlag <= 1'b1;
            else if (ClearErr)    ParityErrFlag <= 1'b0;
            if (RxFrameErr)       FrameErrFlag <= 1'b1;
            else if (ClearErr)    FrameErrFlag <= 1'b0;
        end
    end

    // Registered from current state, so it trails Count/flags by one cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            RxIntReq <= 1'b0;
        else
            RxIntReq <= (Count > {1'b0, IntLevel}) | OverrunErr | ParityErrFlag | FrameErrFlag;
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] idleCnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            idleCnt       <= 16'd0;
            TimeoutIntReq <= 1'b0;
        end else begin
            // Any FIFO activity or an empty FIFO restarts the idle window.
            if (pushEn | popEn | Flush | Empty)
                idleCnt <= 16'd0;
            else if (idleCnt < TimeoutLimit)
                idleCnt <= idleCnt + 16'd1;
            else
                idleCnt <= TimeoutLimit;

            if (popEn | Flush)
                TimeoutIntReq <= 1'b0;
            else if ((idleCnt == TimeoutLimit) && !Empty)
                TimeoutIntReq <= 1'b1;
        end
    end
`else
    // Limit is not used in this build; the reduction only keeps lint quiet.
    logic unusedTimeoutLimit;
    assign unusedTimeoutLimit = ^TimeoutLimit;
    assign TimeoutIntReq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        RxReady;
    logic [7:0]  RxData;
    logic        RxParityErr;
    logic        RxFrameErr;
    logic        ReadEn;
    logic        Flush;
    logic        ClearErr;
    logic [3:0]  IntLevel;
    logic [15:0] TimeoutLimit;
    logic [7:0]  ReadData;
    logic [4:0]  Count;
    logic        Empty;
    logic        Full;
    logic        OverrunErr;
    logic        ParityErrFlag;
    logic        FrameErrFlag;
    logic        RxIntReq;
    logic        TimeoutIntReq;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo dut (
        .Clock(Clock), .Reset(Reset), .RxReady(RxReady), .RxData(RxData),
        .RxParityErr(RxParityErr), .RxFrameErr(RxFrameErr), .ReadEn(ReadEn),
        .Flush(Flush), .ClearErr(ClearErr), .IntLevel(IntLevel),
        .TimeoutLimit(TimeoutLimit), .ReadData(ReadData), .Count(Count),
        .Empty(Empty), .Full(Full), .OverrunErr(OverrunErr),
        .ParityErrFlag(ParityErrFlag), .FrameErrFlag(FrameErrFlag),
        .RxIntReq(RxIntReq), .TimeoutIntReq(TimeoutIntReq)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        RxReady = 1'b1; RxData = b;
        tick();
        RxReady = 1'b0;
    endtask

    task automatic pop();
        ReadEn = 1'b1;
        tick();
        ReadEn = 1'b0;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, ".Count"},   32'(Count), 32'd0);
        chk({tag, ".Empty"},   32'(Empty), 32'd1);
        chk({tag, ".Full"},    32'(Full), 32'd0);
        chk({tag, ".Ovr"},     32'(OverrunErr), 32'd0);
        chk({tag, ".Par"},     32'(ParityErrFlag), 32'd0);
        chk({tag, ".Frm"},     32'(FrameErrFlag), 32'd0);
        chk({tag, ".RxInt"},   32'(RxIntReq), 32'd0);
        chk({tag, ".TmoInt"},  32'(TimeoutIntReq), 32'd0);
    endtask

    initial begin
        Reset = 1'b0; RxReady = 1'b0; RxData = 8'h00; RxParityErr = 1'b0;
        RxFrameErr = 1'b0; ReadEn = 1'b0; Flush = 1'b0; ClearErr = 1'b0;
        IntLevel = 4'd15; TimeoutLimit = 16'd100;
        #3;
        chkReset("reset");
        tick();
        Reset = 1'b1;
        tick();

        // three pushes, fall-through head, then drain
        push(8'h41); push(8'h42); push(8'h43);
        chk("fill3.Count", 32'(Count), 32'd3);
        chk("fill3.Head",  32'(ReadData), 32'h41);
        pop();
        chk("pop1.Head",   32'(ReadData), 32'h42);
        pop();
        chk("pop2.Head",   32'(ReadData), 32'h43);
        pop();
        chk("pop3.Empty",  32'(Empty), 32'd1);
        chk("pop3.Count",  32'(Count), 32'd0);
        pop();
        chk("popEmpty.Count", 32'(Count), 32'd0);
        chk("popEmpty.Empty", 32'(Empty), 32'd1);

        // fill to 16, then overrun with 0x10
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill16.Full", 32'(Full), 32'd1);
        chk("fill16.Ovr",  32'(OverrunErr), 32'd0);
        push(8'h10);
        chk("ovr.Count", 32'(Count), 32'd16);
        chk("ovr.Ovr",   32'(OverrunErr), 32'd1);
        chk("ovr.Head",  32'(ReadData), 32'h00);
        ClearErr = 1'b1; tick(); ClearErr = 1'b0;
        chk("clr.Ovr",   32'(OverrunErr), 32'd0);

        // simultaneous push and pop while full
        RxReady = 1'b1; RxData = 8'hAA; ReadEn = 1'b1;
        tick();
        RxReady = 1'b0; ReadEn = 1'b0;
        chk("fullRW.Count", 32'(Count), 32'd16);
        chk("fullRW.Ovr",   32'(OverrunErr), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("drain.Data", 32'(ReadData), 32'(i));
            pop();
        end
        chk("drain.AA",    32'(ReadData), 32'hAA);
        pop();
        chk("drain.Empty", 32'(Empty), 32'd1);
        tick();
        chk("drain.RxInt", 32'(RxIntReq), 32'd0);

        // interrupt threshold and error flags
        IntLevel = 4'd3;
        push(8'h01); push(8'h02); push(8'h03);
        tick();
        chk("lvl3.RxInt", 32'(RxIntReq), 32'd0);
        push(8'h04);
        chk("lvl4.Count", 32'(Count), 32'd4);
        chk("lvl4.RxIntLag", 32'(RxIntReq), 32'd0);
        tick();
        chk("lvl4.RxInt", 32'(RxIntReq), 32'd1);
        pop();
        chk("lvlPop.Count", 32'(Count), 32'd3);
        chk("lvlPop.RxIntLag", 32'(RxIntReq), 32'd1);
        tick();
        chk("lvlPop.RxInt", 32'(RxIntReq), 32'd0);
        RxFrameErr = 1'b1; tick(); RxFrameErr = 1'b0;
        chk("frm.Flag", 32'(FrameErrFlag), 32'd1);
        tick();
        chk("frm.RxInt", 32'(RxIntReq), 32'd1);
        RxParityErr = 1'b1; ClearErr = 1'b1; tick();
        RxParityErr = 1'b0; ClearErr = 1'b0;
        chk("setWins.Par", 32'(ParityErrFlag), 32'd1);
        chk("setWins.Frm", 32'(FrameErrFlag), 32'd0);
        ClearErr = 1'b1; tick(); ClearErr = 1'b0;
        chk("clr.Par", 32'(ParityErrFlag), 32'd0);

        // flush discards data and a same-cycle byte but keeps flags
        Flush = 1'b1; tick(); Flush = 1'b0;
        chk("flush.Count", 32'(Count), 32'd0);
        push(8'h11); push(8'h22);
        RxFrameErr = 1'b1; tick(); RxFrameErr = 1'b0;
        Flush = 1'b1; RxReady = 1'b1; RxData = 8'h55;
        tick();
        Flush = 1'b0; RxReady = 1'b0;
        chk("flushRx.Count", 32'(Count), 32'd0);
        chk("flushRx.Empty", 32'(Empty), 32'd1);
        chk("flushRx.Frm",   32'(FrameErrFlag), 32'd1);
        push(8'h66);
        chk("flushRx.Head",  32'(ReadData), 32'h66);
        chk("flushRx.Cnt1",  32'(Count), 32'd1);
        ClearErr = 1'b1; tick(); ClearErr = 1'b0;

        // async reset mid-fill
        push(8'h77); push(8'h78);
        #2 Reset = 1'b0;
        #1;
        chkReset("midReset");
        tick();
        Reset = 1'b1;
        tick();

        // simultaneous push and pop while empty stores the byte
        IntLevel = 4'd15;
        RxReady = 1'b1; RxData = 8'h5A; ReadEn = 1'b1;
        tick();
        RxReady = 1'b0; ReadEn = 1'b0;
        chk("emptyRW.Count", 32'(Count), 32'd1);
        chk("emptyRW.Head",  32'(ReadData), 32'h5A);
        pop();
        chk("emptyRW.Empty", 32'(Empty), 32'd1);

        // idle timeout: counter reaches 100 on the 100th idle edge,
        // the interrupt registers one edge later
        push(8'h99);
        repeat (100) tick();
        chk("tmo.Before", 32'(TimeoutIntReq), 32'd0);
        tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        chk("tmo.Set", 32'(TimeoutIntReq), 32'd1);
`else
        chk("tmo.Off", 32'(TimeoutIntReq), 32'd0);
`endif
        pop();
        chk("tmo.Clear", 32'(TimeoutIntReq), 32'd0);
        chk("tmo.Empty", 32'(Empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of FIFO entries; fixed at 16 with 4-bit pointers.
REQ-002 Clock  in  1  system clock; all state updates on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 RxReady  in  1  one-cycle strobe from the receiver; RxData valid in the same cycle.
REQ-005 RxData  in  8  received byte.
REQ-006 RxParityErr  in  1  one-cycle parity error pulse from the receiver.
REQ-007 RxFrameErr  in  1  one-cycle framing error pulse from the receiver.
REQ-008 ReadEn  in  1  CPU pop request for the head entry.
REQ-009 Flush  in  1  synchronous FIFO discard.
REQ-010 ClearErr  in  1  clears the sticky error flags.
REQ-011 IntLevel  in  4  receive-interrupt threshold.
REQ-012 TimeoutLimit  in  16  idle-timeout limit in clocks.
REQ-013 ReadData  out  8  head entry (first-word fall-through); undefined when Empty = 1.
REQ-014 Count  out  5  occupancy, 0..16.
REQ-015 Empty / Full  out  1 each  Count == 0 / Count == 16.
REQ-016 OverrunErr, ParityErrFlag, FrameErrFlag  out  1 each  sticky error flags.
REQ-017 RxIntReq  out  1  level interrupt.
REQ-018 TimeoutIntReq  out  1  idle-timeout interrupt.

Function
REQ-019 Push shall occur when RxReady = 1 and the FIFO is not full: RxData is written at the write pointer, the write pointer increments, and the pointer wraps from 15 to 0.
REQ-020 Pop shall occur when ReadEn = 1 and Empty = 0: the read pointer increments with wrap, and ReadData shows the next entry in the following cycle.
REQ-021 ReadEn while empty shall be ignored, and no state shall change.
REQ-022 RxReady while full with no pop in the same cycle shall drop the byte, leave the pointers unchanged, and set OverrunErr.
REQ-023 RxReady and a pop in the same cycle while full shall perform both operations, leave Count at 16, and not set OverrunErr.
REQ-024 RxReady and ReadEn in the same cycle while empty shall store the byte and ignore the pop, giving Count = 1.
REQ-025 Count shall be +1 on push only, -1 on pop only, and unchanged on both or neither; Count shall update one cycle after the operating edge.
REQ-026 Flush shall take priority over push and pop: both pointers and Count are set to 0, any same-cycle RxReady byte is discarded, and the error flags are unaffected.
REQ-027 ParityErrFlag and FrameErrFlag shall be set on their input pulse and cleared by ClearErr; in the same cycle, set wins over clear. Errored frames are never pushed, because the receiver does not assert RxReady for them.
REQ-028 OverrunErr shall be cleared by ClearErr, with set winning over clear.
REQ-029 RxIntReq shall be the registered value of (Count > IntLevel) OR any sticky error flag.

Reset
REQ-030 When Reset is low, the block shall asynchronously set: pointers = 0, Count = 0, Empty = 1, Full = 0, all error flags = 0, RxIntReq = 0, TimeoutIntReq = 0, timeout counter = 0.
REQ-031 Storage array contents shall not be reset.
REQ-032 Reset asserted mid-operation shall discard all stored bytes.

Configuration
REQ-033 With UART_RX_FIFO_TIMEOUT_EN defined, a 16-bit idle counter shall:
- reset to 0 on any push, pop, Flush, or when Empty = 1;
- otherwise increment, saturating at TimeoutLimit;
- set TimeoutIntReq when it equals TimeoutLimit with Empty = 0.
REQ-034 With UART_RX_FIFO_TIMEOUT_EN defined, TimeoutIntReq shall clear on the next pop or Flush.
REQ-035 Without UART_RX_FIFO_TIMEOUT_EN, TimeoutIntReq shall be tied to 0, TimeoutLimit shall be ignored, and no counter logic shall be synthesized.

Verification
REQ-036 Push 0x41, 0x42, 0x43 with no reads -> Count = 3, ReadData = 0x41; after 3 pops -> ReadData sequence 0x41/0x42/0x43 and Empty = 1.
REQ-037 Push 17 bytes 0x00..0x10 -> Full = 1, OverrunErr = 1, 0x10 lost; then ClearErr -> OverrunErr = 0.
REQ-038 Full FIFO with simultaneous RxReady (0xAA) and ReadEn -> Count stays 16, OverrunErr = 0, 0xAA is popped 16th.
REQ-039 IntLevel = 3: 4th push -> RxIntReq = 1 the cycle after Count = 4; pop -> RxIntReq = 0 after Count = 3; RxFrameErr pulse -> FrameErrFlag = 1 and RxIntReq = 1.
REQ-040 Push 2 bytes, Flush together with RxReady (0x55) -> Count = 0, Empty = 1, 0x55 not stored; Reset low mid-fill -> all outputs at their reset values.
REQ-041 With UART_RX_FIFO_TIMEOUT_EN and TimeoutLimit = 100: 1 byte pushed then idle -> TimeoutIntReq = 1 after 100 clocks; pop -> TimeoutIntReq = 0. Without the macro -> TimeoutIntReq stays 0.
